north_feed_scheduler: RTL and testbench
=======================================

# north_feed_scheduler

Sequencer for the per-column north FIFOs that feed the systolic MAC array. After a single `start` pulse it issues read enables with the diagonal skew the array needs: column i begins i steps after column 0, and each column reads `len` words. All columns advance in lockstep, so an empty FIFO stalls the whole wavefront and the skew is kept. It sits between the FIFO bank (`empty`/`rd_en`) and the MAC array edge (`valid_out`).

## Interface
- `NUM_COLS`, default 256: number of array columns, which is also the number of north FIFOs.
- `LEN_WIDTH`, default 8: width of the per-pass word count.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request to begin a pass; sampled only in IDLE.
- `len`  in  LEN_WIDTH  words per column; latched when `start` is accepted.
- `empty_in`  in  NUM_COLS  per-column FIFO empty flags.
- `rd_en_out`  out  NUM_COLS  per-column FIFO read enables.
- `valid_out`  out  NUM_COLS  per-column data-valid at the array edge.
- `stall`  out  1  wavefront is held this cycle.
- `busy`  out  1  a pass is in progress.
- `done`  out  1  one-cycle pass-complete pulse.

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE -> RUN when `start`=1 and `len`≠0.
  - Latch `len` and clear the step counter t to 0.
  - `start` with `len`=0 is ignored: no state change, no `done`.
- RUN:
  - Column i is active when i ≤ t < i+len.
  - `stall` = OR over active columns of `empty_in[i]`.
  - `rd_en_out[i]` = active_i AND NOT `stall`. This path is combinational from `empty_in`.
  - t increments only when `stall`=0.
- RUN -> DONE on the non-stalled step where t = len+NUM_COLS−2, i.e. the last of len+NUM_COLS−1 steps.
- DONE -> IDLE after one cycle. `done`=1 only in DONE.
- `busy` = 1 exactly in RUN.
- `start` is ignored in RUN and DONE.
- Width rules:
  - t is LEN_WIDTH+clog2(NUM_COLS)+1 bits, so there is no wrap at max `len` and max `NUM_COLS`.
  - All comparisons are unsigned.
- `valid_out` = `rd_en_out` registered one cycle, matching the FIFO's registered read data.
- A stall produces an all-zero `valid_out` bubble. The MAC array must hold on bubbles.
- `rd_en_out` is never asserted to a column whose `empty_in`=1, and never outside RUN.
- Reset value of every output is 0: `rd_en_out`, `valid_out`, `stall`, `busy`, `done`.
- `reset`=0 in any state, including mid-pass:
  - State becomes IDLE and t clears.
  - All outputs are 0 from the next cycle.
  - The partial pass is abandoned. FIFO contents are the owner's problem.
- `reset` has priority over `start` in the same cycle.

## Timing
- `start` is sampled at edge E0. RUN begins in cycle 1 with t=0, and `rd_en_out[0]` is high in cycle 1 if not stalled.
- Unstalled pass: RUN lasts len+NUM_COLS−1 cycles. `done` is in cycle len+NUM_COLS, and IDLE resumes in the following cycle.
- Each stalled cycle adds exactly one cycle to the pass.
- `valid_out` lags `rd_en_out` by exactly one cycle. The final `valid_out` beat coincides with `done`.
- Earliest next accepted `start`: the first IDLE cycle after DONE. A new pass starts with RUN in the next cycle.

## Test plan
Bench uses NUM_COLS=4, LEN_WIDTH=4.
- **Basic pass.** `len`=3, all FIFOs non-empty, `start` at cycle 0 -> `rd_en_out` for cycles 1..6 = 0001, 0011, 0111, 1110, 1100, 1000; `done`=1 in cycle 7 only; `busy`=1 in cycles 1..6.
- **Stall.** Same pass, `empty_in[2]`=1 during cycle 3 only -> cycle 3: `rd_en_out`=0000 and `stall`=1; cycle 4: 0111; remaining pattern shifted by one; `done` in cycle 8.
- **Ignored starts.** `start` with `len`=0 in IDLE -> stays IDLE, `done` never asserts. `start` pulsed during RUN -> no effect, single `done`.
- **Reset mid-pass.** `reset`=0 in cycle 3 of the basic pass -> cycle 4: all outputs 0, state IDLE. A fresh `start` with `len`=2 -> `rd_en_out` for cycles 1..5 = 0001, 0011, 0110, 1100, 1000; `done` in cycle 6 (cycles counted from the fresh `start`).
- **Max length.** `len`=15 -> 18 RUN steps, `done` in cycle 19; `rd_en_out[3]` high in cycles 4..18; no counter wrap.
- **Valid alignment.** In all scenarios, `valid_out`(n) == `rd_en_out`(n−1), and `valid_out`=0 in the cycle after reset.

Source files
------------

// File: rtl/north_feed_scheduler.sv
// Skewed read-enable sequencer for the north FIFO bank feeding the systolic array.
// Column i reads len words starting i steps after column 0; any empty active FIFO holds the wavefront.
module north_feed_scheduler #(
  parameter int NUM_COLS  = 256,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [NUM_COLS-1:0]  empty_in,
  output logic [NUM_COLS-1:0]  rd_en_out,
  output logic [NUM_COLS-1:0]  valid_out,
  output logic                 stall,
  output logic                 busy,
  output logic                 done
);

  localparam int TW = LEN_WIDTH + $clog2(NUM_COLS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg;
  logic [TW-1:0]        t_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [NUM_COLS-1:0]  valid_reg;

  logic [NUM_COLS-1:0]  active;
  logic [TW-1:0]        len_ext;
  logic [TW-1:0]        last_step;
  logic                 in_run;

  assign in_run    = (state_reg == RUN);
  assign len_ext   = TW'(len_reg);
  assign last_step = len_ext + TW'(NUM_COLS) - TW'(2);

  // When t < i the difference wraps to at least 2^TW - NUM_COLS, which always exceeds
  // the largest len, so one unsigned compare covers both i <= t and t < i + len.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
      localparam logic [TW-1:0] COL_IDX = TW'(gi);
      assign active[gi] = in_run && ((t_reg - COL_IDX) < len_ext);
    end
  endgenerate

  assign stall     = |(active & empty_in);
  assign rd_en_out = active & {NUM_COLS{~stall}};
  assign valid_out = valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      len_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= '0;
    end else begin
      valid_reg <= rd_en_out;
      case (state_reg)
        IDLE: begin
          if (start && (len != '0)) begin
            state_reg <= RUN;
            t_reg     <= '0;
            len_reg   <= len;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (!stall) begin
            if (t_reg == last_step) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              t_reg <= t_reg + TW'(1);
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_north_feed_scheduler.sv
// Bench for north_feed_scheduler (4 columns, 4-bit len): directed passes plus random traffic
// checked every cycle against a pass-level reference model.
module tb_north_feed_scheduler;

  localparam int NC = 4;
  localparam int LW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [LW-1:0] len;
  logic [NC-1:0] empty_in;
  logic [NC-1:0] rd_en_out;
  logic [NC-1:0] valid_out;
  logic          stall;
  logic          busy;
  logic          done;

  int vec_count = 0;
  int err_count = 0;

  north_feed_scheduler #(.NUM_COLS(NC), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .empty_in  (empty_in),
    .rd_en_out (rd_en_out),
    .valid_out (valid_out),
    .stall     (stall),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a pass is "steps taken so far" out of len+NC-1 total steps;
  // column i reads on steps i .. i+len-1, and a step is only taken when no reading column is empty.
  int            m_phase;   // 0 idle, 1 running, 2 done cycle
  int            m_step;
  int            m_len;
  logic [NC-1:0] m_prev_rd;
  logic [NC-1:0] m_act;
  logic [NC-1:0] m_exp_rd;
  logic          m_exp_stall;

  initial begin
    m_phase   = 0;
    m_step    = 0;
    m_len     = 0;
    m_prev_rd = '0;
  end

  always @(negedge clk) begin
    m_act = '0;
    if (m_phase == 1)
      for (int i = 0; i < NC; i++)
        m_act[i] = (m_step >= i) && (m_step < i + m_len);
    m_exp_stall = |(m_act & empty_in);
    m_exp_rd    = m_exp_stall ? '0 : m_act;

    check_eq("rd_en_out", 32'(rd_en_out), 32'(m_exp_rd));
    check_eq("stall",     32'(stall),     32'(m_exp_stall));
    check_eq("busy",      32'(busy),      32'(m_phase == 1));
    check_eq("done",      32'(done),      32'(m_phase == 2));
    check_eq("valid_out", 32'(valid_out), 32'(m_prev_rd));

    if (m_phase == 2)
      $display("txn: pass complete len=%0d at %0t", m_len, $time);

    m_prev_rd = m_exp_rd;
    if (!reset) begin
      m_phase   = 0;
      m_step    = 0;
      m_prev_rd = '0;
    end else if (m_phase == 0) begin
      if (start && len != 0) begin
        m_phase = 1;
        m_step  = 0;
        m_len   = int'(len);
      end
    end else if (m_phase == 1) begin
      if (!m_exp_stall) begin
        m_step++;
        if (m_step == m_len + NC - 1) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  logic [NC-1:0] basic_tbl [0:8];
  logic [NC-1:0] short_tbl [0:7];
  int            done_seen;

  initial begin
    basic_tbl = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    short_tbl = '{4'h0, 4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h0, 4'h0};
    reset = 1'b0; start = 1'b0; len = '0; empty_in = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Basic pass, len=3
    len = 4'd3; start = 1'b1; tick(); start = 1'b0; len = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check_eq("basic_rd", 32'(rd_en_out), 32'(basic_tbl[c]));
      check_eq("basic_done", 32'(done), 32'(c == 7));
      tick();
    end

    // Stall on column 2 during cycle 3
    len = 4'd3; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    empty_in = 4'b0100;
    @(negedge clk);
    check_eq("stall_flag", 32'(stall), 32'd1);
    check_eq("stall_rd", 32'(rd_en_out), 32'd0);
    tick();
    empty_in = '0;
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      check_eq("stall_shift_rd", 32'(rd_en_out), 32'(basic_tbl[c - 1]));
      check_eq("stall_done", 32'(done), 32'(c == 8));
      tick();
    end

    // start with len=0 is ignored
    len = 4'd0; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check_eq("len0_busy", 32'(busy), 32'd0);
      check_eq("len0_done", 32'(done), 32'd0);
      tick();
    end

    // start pulsed mid-pass is ignored
    done_seen = 0;
    len = 4'd2; start = 1'b1; tick(); start = 1'b0;
    tick();
    len = 4'd5; start = 1'b1; tick(); start = 1'b0;
    for (int c = 3; c <= 12; c++) begin
      @(negedge clk);
      if (done) done_seen++;
      tick();
    end
    check_eq("run_start_done_count", 32'(done_seen), 32'd1);

    // Reset mid-pass, then a fresh len=2 pass
    len = 4'd3; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    reset = 1'b0; tick(); reset = 1'b1;
    @(negedge clk);
    check_eq("rst_outputs", 32'({rd_en_out, valid_out, stall, busy, done}), 32'd0);
    tick();
    len = 4'd2; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check_eq("fresh_rd", 32'(rd_en_out), 32'(short_tbl[c]));
      check_eq("fresh_done", 32'(done), 32'(c == 6));
      tick();
    end

    // Maximum length
    len = 4'd15; start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check_eq("max_rd3", 32'(rd_en_out[3]), 32'(c >= 4 && c <= 18));
      check_eq("max_busy", 32'(busy), 32'(c >= 1 && c <= 18));
      check_eq("max_done", 32'(done), 32'(c == 19));
      tick();
    end

    // Random traffic: sparse resets, frequent starts (some len=0), random empties
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) != 0);
      start    = ($urandom_range(0, 5) == 0);
      len      = ($urandom_range(0, 4) == 0) ? 4'd0 : LW'($urandom_range(1, 15));
      for (int i = 0; i < NC; i++) empty_in[i] = ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 1'b1; start = 1'b0; empty_in = '0;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
